// File: rtl/golomb_pkg.sv
// Shared types and defaults for the Golomb ruler search sequencer.
package golomb_pkg;

    localparam int VW_DEF       = 9;
    localparam int LW_DEF       = 7;
    localparam int MAXVALUE_DEF = 500;
    localparam int MAX_MARKS    = 32;
    localparam int MAX_FLAT     = MAX_MARKS * VW_DEF;

    typedef enum logic [2:0] {IDLE, CLR, STEP, WAIT, EVAL, DONE} state_e;

    // Mark i of a flat vector holding n_marks marks, m[0] in the MSBs.
    function automatic logic [VW_DEF-1:0] mark_at(input logic [MAX_FLAT-1:0] flat,
                                                  input int n_marks, input int i);
        return flat[(n_marks - 1 - i) * VW_DEF +: VW_DEF];
    endfunction

endpackage

// File: rtl/golomb_search_sequencer_if.sv
// Handshake/bus bundle between the search sequencer and its host plus the mark-counter chain.
interface golomb_search_sequencer_if #(
    parameter int NUMPOSITIONS = 5,
    parameter int VW           = 9,
    parameter int LW           = 7
);
    logic                            start;
    logic [VW-1:0]                   init_limit;
    logic                            chain_reset;
    logic                            step;
    logic [LW-1:0]                   enabled;
    logic [VW-1:0]                   limit;
    logic                            ready;
    logic [LW-1:0]                   next_enabled;
    logic                            success;
    logic [(NUMPOSITIONS+1)*VW-1:0]  marks_in;
    logic [(NUMPOSITIONS+1)*VW-1:0]  best_marks;
    logic [VW-1:0]                   best_length;
    logic [15:0]                     found_count;
    logic [31:0]                     step_count;
    logic                            busy;
    logic                            done;
    logic                            error;

    modport master (
        input  start, init_limit, ready, next_enabled, success, marks_in,
        output chain_reset, step, enabled, limit, best_marks, best_length,
               found_count, step_count, busy, done, error
    );

    modport slave (
        output start, init_limit, ready, next_enabled, success, marks_in,
        input  chain_reset, step, enabled, limit, best_marks, best_length,
               found_count, step_count, busy, done, error
    );
endinterface

// File: rtl/golomb_best_store.sv
// Best-ruler snapshot, success counter and limit candidate.
// ALL_OPTIMAL_EN: candidate limit is the ruler length itself instead of length-1.
module golomb_best_store
    import golomb_pkg::*;
#(
    parameter int NUMPOSITIONS = 5,
    parameter int VW           = VW_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear_i,
    input  logic                           capture_i,
    input  logic [(NUMPOSITIONS+1)*VW-1:0] marks_in_i,
    output logic [(NUMPOSITIONS+1)*VW-1:0] best_marks_o,
    output logic [VW-1:0]                  best_length_o,
    output logic [15:0]                    found_count_o,
    output logic [VW-1:0]                  lim_cand_o,
    output logic                           lim_cand_ok_o
);
    localparam int FW = (NUMPOSITIONS + 1) * VW;

    logic [FW-1:0] best_q, best_d;
    logic [VW-1:0] len_q, len_d;
    logic [15:0]   found_q, found_d;
    logic [VW-1:0] last;

    assign last = VW'(mark_at({{(MAX_FLAT-FW){1'b0}}, marks_in_i}, NUMPOSITIONS + 1, NUMPOSITIONS));

    always_comb begin
        best_d  = best_q;
        len_d   = len_q;
        found_d = found_q;
        if (clear_i) begin
            best_d  = '0;
            len_d   = '0;
            found_d = '0;
        end else if (capture_i) begin
            best_d = marks_in_i;
            len_d  = last;
            if (found_q != 16'hFFFF) found_d = found_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            best_q  <= '0;
            len_q   <= '0;
            found_q <= '0;
        end else begin
            best_q  <= best_d;
            len_q   <= len_d;
            found_q <= found_d;
        end
    end

`ifdef ALL_OPTIMAL_EN
    assign lim_cand_o = last;
`else
    assign lim_cand_o = last - 1'b1;
`endif
    // A zero-length ruler would wrap the limit, so it never qualifies.
    assign lim_cand_ok_o = (last != '0);

    assign best_marks_o  = best_q;
    assign best_length_o = len_q;
    assign found_count_o = found_q;
endmodule

// File: rtl/golomb_search_sequencer.sv
// Central FSM for the mark-counter chain: token, step pulses, limit tightening, completion.
// ALL_OPTIMAL_EN (in golomb_best_store) keeps the limit at the best length to enumerate ties.
module golomb_search_sequencer
    import golomb_pkg::*;
#(
    parameter int NUMPOSITIONS = 5,
    parameter int MAXVALUE     = MAXVALUE_DEF,
    parameter int VW           = VW_DEF,
    parameter int LW           = LW_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    golomb_search_sequencer_if.master  bus
);
    state_e        state_q, state_d;
    logic [LW-1:0] enabled_q, enabled_d;
    logic [VW-1:0] limit_q, limit_d;
    logic [31:0]   step_count_q, step_count_d;
    logic          error_q, error_d;
    logic          step_q, step_d;
    logic          chain_reset_q, chain_reset_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          clear, capture;
    logic [VW-1:0] lim_cand, lim_init;
    logic          lim_cand_ok;

    golomb_best_store #(.NUMPOSITIONS(NUMPOSITIONS), .VW(VW)) u_best (
        .clock         (clock),
        .reset         (reset),
        .clear_i       (clear),
        .capture_i     (capture),
        .marks_in_i    (bus.marks_in),
        .best_marks_o  (bus.best_marks),
        .best_length_o (bus.best_length),
        .found_count_o (bus.found_count),
        .lim_cand_o    (lim_cand),
        .lim_cand_ok_o (lim_cand_ok)
    );

    assign lim_init = (bus.init_limit == '0 || bus.init_limit > VW'(MAXVALUE))
                      ? VW'(MAXVALUE) : bus.init_limit;

    always_comb begin
        state_d      = state_q;
        enabled_d    = enabled_q;
        limit_d      = limit_q;
        step_count_d = step_count_q;
        error_d      = error_q;
        clear        = 1'b0;
        capture      = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d      = CLR;
                    limit_d      = lim_init;
                    step_count_d = '0;
                    error_d      = 1'b0;
                    clear        = 1'b1;
                end
            end
            CLR:  state_d = STEP;
            STEP: begin
                state_d = WAIT;
                if (step_count_q != 32'hFFFF_FFFF) step_count_d = step_count_q + 32'd1;
            end
            WAIT: if (bus.ready) state_d = EVAL;
            EVAL: begin
                capture = bus.success;
                // Only ever tighten: the limit is monotonic within a search.
                if (bus.success && lim_cand_ok && lim_cand < limit_q) limit_d = lim_cand;
                if (bus.next_enabled == '0) begin
                    state_d = DONE;
                end else if (bus.next_enabled > LW'(NUMPOSITIONS)) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    enabled_d = bus.next_enabled;
                    state_d   = STEP;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == CLR) enabled_d = LW'(1);
        step_d        = (state_d == STEP);
        chain_reset_d = (state_d == CLR);
        busy_d        = !(state_d == IDLE || state_d == DONE);
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            enabled_q     <= LW'(1);
            limit_q       <= VW'(MAXVALUE);
            step_count_q  <= '0;
            error_q       <= 1'b0;
            step_q        <= 1'b0;
            chain_reset_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            enabled_q     <= enabled_d;
            limit_q       <= limit_d;
            step_count_q  <= step_count_d;
            error_q       <= error_d;
            step_q        <= step_d;
            chain_reset_q <= chain_reset_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.enabled     = enabled_q;
    assign bus.limit       = limit_q;
    assign bus.step_count  = step_count_q;
    assign bus.error       = error_q;
    assign bus.step        = step_q;
    assign bus.chain_reset = chain_reset_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_golomb_search_sequencer.sv
// Bench for golomb_search_sequencer: behavioural chain stub, directed scenarios and a randomized model run.
module tb_golomb_search_sequencer;
    localparam int NP   = 5;
    localparam int MAXV = 500;
    localparam int VW   = 9;
    localparam int LW   = 7;
    localparam int FW   = (NP + 1) * VW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    golomb_search_sequencer_if #(.NUMPOSITIONS(NP), .VW(VW), .LW(LW)) bus();

    golomb_search_sequencer #(.NUMPOSITIONS(NP), .MAXVALUE(MAXV), .VW(VW), .LW(LW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] pack6(input int a, input int b, input int c,
                                            input int d, input int e, input int f);
        logic [FW-1:0] r;
        int m [6];
        m = '{a, b, c, d, e, f};
        r = '0;
        for (int i = 0; i < 6; i++) r[(5 - i) * VW +: VW] = m[i][VW-1:0];
        return r;
    endfunction

    function automatic int clamp_limit(input int il);
        return (il == 0 || il > MAXV) ? MAXV : il;
    endfunction

    // Limit the search should hold after a success with ruler length len.
    function automatic int after_success(input int lim, input int len);
        int cand;
`ifdef ALL_OPTIMAL_EN
        cand = len;
`else
        cand = len - 1;
`endif
        if (len == 0) return lim;
        return (cand < lim) ? cand : lim;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int il);
        bus.init_limit = VW'(il);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Stub response: ready low for dly cycles from now, then high with fields held.
    task automatic respond(input int dly, input int ne, input bit succ, input logic [FW-1:0] m);
        bus.next_enabled = LW'(ne);
        bus.success      = succ;
        bus.marks_in     = m;
        bus.ready        = (dly == 0);
        for (int i = 0; i < dly; i++) tick();
        bus.ready = 1'b1;
    endtask

    task automatic wait_evt(output bit got);
        int n;
        got = 1'b0;
        n = 0;
        while (!got && n < 100) begin
            tick();
            n++;
            if (bus.step || bus.done) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (bus.enabled !== LW'(1) || bus.limit !== VW'(MAXV) || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.step !== 1'b0 || bus.chain_reset !== 1'b0 ||
            bus.error !== 1'b0 || bus.found_count !== 16'd0 || bus.step_count !== 32'd0 ||
            bus.best_length !== '0 || bus.best_marks !== '0) begin
            $display("FAIL reset_values: en=%0d lim=%0d busy=%0b done=%0b step=%0b cr=%0b err=%0b fc=%0d sc=%0d want en=1 lim=%0d rest 0",
                     bus.enabled, bus.limit, bus.busy, bus.done, bus.step, bus.chain_reset,
                     bus.error, bus.found_count, bus.step_count, MAXV);
            miscompares++;
        end
    endtask

    task automatic test_start_timing();
        bit got;
        do_start(0);
        vectors++;
        if (bus.chain_reset !== 1'b1 || bus.step !== 1'b0 || bus.limit !== VW'(MAXV) || bus.busy !== 1'b1) begin
            $display("FAIL start_cycle1: cr=%0b step=%0b lim=%0d busy=%0b want 1 0 %0d 1",
                     bus.chain_reset, bus.step, bus.limit, bus.busy, MAXV);
            miscompares++;
        end
        tick();
        vectors++;
        if (bus.step !== 1'b1 || bus.chain_reset !== 1'b0 || bus.enabled !== LW'(1)) begin
            $display("FAIL start_cycle2: step=%0b cr=%0b en=%0d want 1 0 1", bus.step, bus.chain_reset, bus.enabled);
            miscompares++;
        end
        for (int p = 0; p < 3; p++) begin
            respond(0, p + 2, 1'b0, '0);
            tick();
            tick();
            vectors++;
            if (bus.step !== 1'b0) begin
                $display("FAIL step_gap_%0d: step=%0b at +2 want 0", p, bus.step);
                miscompares++;
            end
            tick();
            vectors++;
            if (bus.step !== 1'b1 || bus.enabled !== LW'(p + 2)) begin
                $display("FAIL step_period_%0d: step=%0b en=%0d want 1 %0d", p, bus.step, bus.enabled, p + 2);
                miscompares++;
            end
        end
        respond(0, 0, 1'b0, '0);
        wait_evt(got);
        vectors++;
        if (!got || bus.done !== 1'b1 || bus.step_count !== 32'd4) begin
            $display("FAIL timing_done: got=%0b done=%0b sc=%0d want 1 1 4", got, bus.done, bus.step_count);
            miscompares++;
        end
    endtask

    task automatic test_success();
        bit got;
        int want_lim;
        do_start(0);
        tick();
        respond(0, 3, 1'b1, pack6(0, 1, 4, 10, 12, 17));
        wait_evt(got);
`ifdef ALL_OPTIMAL_EN
        want_lim = 17;
`else
        want_lim = 16;
`endif
        vectors++;
        if (!got || bus.step !== 1'b1 || bus.best_length !== VW'(17) || bus.limit !== VW'(want_lim) ||
            bus.found_count !== 16'd1 || bus.enabled !== LW'(3) ||
            bus.best_marks !== pack6(0, 1, 4, 10, 12, 17)) begin
            $display("FAIL success_record: step=%0b len=%0d lim=%0d fc=%0d en=%0d want 1 17 %0d 1 3",
                     bus.step, bus.best_length, bus.limit, bus.found_count, bus.enabled, want_lim);
            miscompares++;
        end
        respond(0, 0, 1'b0, '0);
        wait_evt(got);
    endtask

    task automatic test_done_success();
        bit got;
        do_start(0);
        tick();
        respond(0, 0, 1'b1, pack6(0, 1, 4, 10, 15, 17));
        wait_evt(got);
        vectors++;
        if (!got || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.error !== 1'b0 ||
            bus.best_length !== VW'(17) || bus.found_count !== 16'd1 ||
            bus.best_marks !== pack6(0, 1, 4, 10, 15, 17)) begin
            $display("FAIL done_with_success: done=%0b busy=%0b err=%0b len=%0d fc=%0d want 1 0 0 17 1",
                     bus.done, bus.busy, bus.error, bus.best_length, bus.found_count);
            miscompares++;
        end
    endtask

    task automatic test_error();
        bit got;
        do_start(0);
        tick();
        respond(0, 7, 1'b0, '0);
        wait_evt(got);
        vectors++;
        if (!got || bus.error !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            $display("FAIL error_set: err=%0b done=%0b busy=%0b want 1 1 0", bus.error, bus.done, bus.busy);
            miscompares++;
        end
        do_start(50);
        vectors++;
        if (bus.error !== 1'b0 || bus.limit !== VW'(50) || bus.done !== 1'b0 || bus.chain_reset !== 1'b1) begin
            $display("FAIL error_clear: err=%0b lim=%0d done=%0b cr=%0b want 0 50 0 1",
                     bus.error, bus.limit, bus.done, bus.chain_reset);
            miscompares++;
        end
        tick();
        respond(0, 0, 1'b0, '0);
        wait_evt(got);
    endtask

    task automatic test_ready_delay();
        bit got;
        bit early;
        int r;
        do_start(0);
        tick();
        bus.next_enabled = LW'(2);
        bus.success = 1'b0;
        bus.marks_in = '0;
        bus.ready = 1'b0;
        early = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.step) early = 1'b1;
            if (i == 4) begin
                bus.init_limit = VW'(33);
                bus.start = 1'b1;
            end
            if (i == 5) begin
                bus.start = 1'b0;
                vectors++;
                if (bus.chain_reset !== 1'b0 || bus.limit !== VW'(MAXV) || bus.busy !== 1'b1) begin
                    $display("FAIL start_while_busy: cr=%0b lim=%0d busy=%0b want 0 %0d 1",
                             bus.chain_reset, bus.limit, bus.busy, MAXV);
                    miscompares++;
                end
            end
        end
        bus.ready = 1'b1;
        r = cyc;
        wait_evt(got);
        vectors++;
        if (!got || early || bus.step !== 1'b1 || (cyc - r) != 2 || bus.step_count !== 32'd1) begin
            $display("FAIL ready_delay: early=%0b step=%0b lag=%0d sc=%0d want 0 1 2 1",
                     early, bus.step, cyc - r, bus.step_count);
            miscompares++;
        end
        respond(0, 0, 1'b0, '0);
        wait_evt(got);
    endtask

    task automatic test_reset_in_wait();
        bit got;
        do_start(100);
        tick();
        respond(0, 3, 1'b0, '0);
        wait_evt(got);
        bus.ready = 1'b0;
        tick();
        rst = 1'b1;
        bus.start = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.enabled !== LW'(1) || bus.limit !== VW'(MAXV) ||
            bus.step !== 1'b0 || bus.chain_reset !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL reset_in_wait: busy=%0b en=%0d lim=%0d step=%0b cr=%0b done=%0b want 0 1 %0d 0 0 0",
                     bus.busy, bus.enabled, bus.limit, bus.step, bus.chain_reset, bus.done, MAXV);
            miscompares++;
        end
        tick();
        vectors++;
        if (bus.chain_reset !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL reset_start_ignored: cr=%0b busy=%0b want 0 0", bus.chain_reset, bus.busy);
            miscompares++;
        end
    endtask

    task automatic test_random();
        bit got, fin, succ;
        int il, ne, dly, steps;
        int ms [6];
        logic [FW-1:0] pk;
        int exp_lim, exp_found, exp_len, exp_en;
        bit exp_err;
        logic [FW-1:0] exp_best;
        for (int s = 0; s < 5; s++) begin
            il = (s == 0) ? 0 : (s == 1) ? 511 : $urandom_range(20, 499);
            exp_lim = clamp_limit(il);
            exp_found = 0;
            exp_len = 0;
            exp_best = '0;
            exp_en = 1;
            exp_err = 1'b0;
            do_start(il);
            wait_evt(got);
            steps = 1;
            vectors++;
            if (!got || bus.step !== 1'b1 || bus.limit !== VW'(exp_lim)) begin
                $display("FAIL rnd_first_step_%0d: step=%0b lim=%0d want 1 %0d", s, bus.step, bus.limit, exp_lim);
                miscompares++;
            end
            for (int k = 0; k < 40; k++) begin
                r_pick: begin
                    int p;
                    p = $urandom_range(0, 99);
                    if (k == 39 || p < 6) ne = 0;
                    else if (p < 10) ne = $urandom_range(NP + 1, 127);
                    else ne = $urandom_range(1, NP);
                end
                succ = ($urandom_range(0, 99) < 30);
                ms[5] = $urandom_range(0, 510);
                ms[0] = 0;
                for (int i = 1; i < 5; i++) ms[i] = $urandom_range(0, 511);
                pk = pack6(ms[0], ms[1], ms[2], ms[3], ms[4], ms[5]);
                dly = $urandom_range(0, 3);
                respond(dly, ne, succ, pk);
                fin = 1'b0;
                if (succ) begin
                    if (exp_found < 65535) exp_found++;
                    exp_best = pk;
                    exp_len = ms[5];
                    exp_lim = after_success(exp_lim, ms[5]);
                end
                if (ne == 0) fin = 1'b1;
                else if (ne > NP) begin
                    exp_err = 1'b1;
                    fin = 1'b1;
                end else exp_en = ne;
                wait_evt(got);
                vectors++;
                if (!got) begin
                    $display("FAIL rnd_timeout_%0d_%0d: no step/done within bound", s, k);
                    miscompares++;
                    break;
                end
                vectors++;
                if (bus.limit !== VW'(exp_lim) || bus.found_count !== 16'(exp_found) ||
                    bus.best_length !== VW'(exp_len) || bus.best_marks !== exp_best || bus.error !== exp_err) begin
                    $display("FAIL rnd_results_%0d_%0d: lim=%0d fc=%0d len=%0d err=%0b want %0d %0d %0d %0b",
                             s, k, bus.limit, bus.found_count, bus.best_length, bus.error,
                             exp_lim, exp_found, exp_len, exp_err);
                    miscompares++;
                end
                vectors++;
                if (fin) begin
                    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.step_count !== 32'(steps)) begin
                        $display("FAIL rnd_done_%0d: done=%0b busy=%0b sc=%0d want 1 0 %0d",
                                 s, bus.done, bus.busy, bus.step_count, steps);
                        miscompares++;
                    end
                    break;
                end else begin
                    if (bus.step !== 1'b1 || bus.enabled !== LW'(exp_en) || bus.done !== 1'b0) begin
                        $display("FAIL rnd_step_%0d_%0d: step=%0b en=%0d done=%0b want 1 %0d 0",
                                 s, k, bus.step, bus.enabled, bus.done, exp_en);
                        miscompares++;
                    end
                    steps++;
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.init_limit = '0;
        bus.ready = 1'b0;
        bus.next_enabled = '0;
        bus.success = 1'b0;
        bus.marks_in = '0;
        test_reset();
        test_start_timing();
        test_success();
        test_done_success();
        test_error();
        test_ready_delay();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
